// File: rtl/diffusion_push_engine_if.sv
// Memory-side bus of the diffusion push engine: graph read port and the
// scheduler-arbitrated score port.
interface diffusion_push_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
);
    logic [ADDR_WIDTH-1:0] g_addr;
    logic                  g_rd_en;
    logic [DATA_WIDTH-1:0] g_rdata;
    logic                  s_req;
    logic                  s_gnt;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic                  s_rd_en;
    logic                  s_we;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic [DATA_WIDTH-1:0] s_rdata;

    modport master (
        output g_addr, g_rd_en, s_req, s_addr, s_rd_en, s_we, s_wdata,
        input  g_rdata, s_gnt, s_rdata
    );

    modport slave (
        input  g_addr, g_rd_en, s_req, s_addr, s_rd_en, s_we, s_wdata,
        output g_rdata, s_gnt, s_rdata
    );
endinterface

// File: rtl/diffusion_push_engine.sv
// One diffusion step over a partition: each node's previous score divided by
// its degree is pushed onto the latest score of every neighbour.
module diffusion_push_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13,
    parameter int RD_LAT     = 1,
    parameter int MAX_STEPS  = 7,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   l_step,
    input  logic [ADDR_WIDTH-1:0]   node_offset,
    input  logic [ADDR_WIDTH-1:0]   node_num,
    output logic                    busy,
    output logic                    done,
    diffusion_push_engine_if.master mem
);
    localparam int CW = $clog2(DATA_WIDTH + 4);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_CHK      = 4'd1;
    localparam logic [3:0] ST_RD_PREV  = 4'd2;
    localparam logic [3:0] ST_RD_FIRST = 4'd3;
    localparam logic [3:0] ST_RD_LAST  = 4'd4;
    localparam logic [3:0] ST_DIV      = 4'd5;
    localparam logic [3:0] ST_RD_NEI   = 4'd6;
    localparam logic [3:0] ST_RD_NS    = 4'd7;
    localparam logic [3:0] ST_WR_NS    = 4'd8;
    localparam logic [3:0] ST_NEXT     = 4'd9;
    localparam logic [3:0] ST_FIN      = 4'd10;

    function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (SATURATE && sum[DATA_WIDTH]) begin
            sat_add = '1;
        end else begin
            sat_add = sum[DATA_WIDTH-1:0];
        end
    endfunction

    logic [3:0]            state_r;
    logic [DATA_WIDTH-1:0] l_step_r;
    logic [ADDR_WIDTH-1:0] node_offset_r;
    logic [ADDR_WIDTH-1:0] node_num_r;
    logic [ADDR_WIDTH-1:0] idx_r;
    logic [DATA_WIDTH-1:0] prev_r;
    logic [DATA_WIDTH-1:0] first_r;
    logic [DATA_WIDTH-1:0] last_r;
    logic [DATA_WIDTH-1:0] ptr_r;
    logic [DATA_WIDTH-1:0] quo_r;
    logic [DATA_WIDTH-1:0] rem_r;
    logic [DATA_WIDTH-1:0] div_r;
    logic [CW-1:0]         cnt_r;
    logic                  ph_r;
    logic                  busy_r;
    logic                  done_r;
    logic [ADDR_WIDTH-1:0] g_addr_r;
    logic                  g_rd_en_r;
    logic                  s_req_r;
    logic [ADDR_WIDTH-1:0] s_addr_r;
    logic [DATA_WIDTH-1:0] s_wdata_r;

    logic [DATA_WIDTH:0]   rem_sh_s;
    logic [DATA_WIDTH-1:0] rem_nx_s;
    logic [DATA_WIDTH-1:0] quo_nx_s;
    logic                  lat_done_s;
    logic                  s_ok_s;
    logic [ADDR_WIDTH-1:0] idx_nx_s;
    logic [ADDR_WIDTH-1:0] prev_cur_s;
    logic [ADDR_WIDTH-1:0] prev_nx_s;
    logic [ADDR_WIDTH-1:0] first_addr_s;
    logic [ADDR_WIDTH-1:0] last_addr_s;
    logic [ADDR_WIDTH-1:0] nei_addr_s;

    // ph_r=0: strobe pending; ph_r=1: counting the read latency after the strobe.
    assign lat_done_s   = ph_r && (cnt_r == CW'(RD_LAT - 1));
    assign s_ok_s       = s_req_r && mem.s_gnt && !ph_r;
    assign idx_nx_s     = idx_r + ADDR_WIDTH'(1);
    assign prev_cur_s   = ADDR_WIDTH'({node_offset_r + idx_r, l_step_r[0]});
    assign prev_nx_s    = ADDR_WIDTH'({node_offset_r + idx_nx_s, l_step_r[0]});
    assign first_addr_s = ADDR_WIDTH'({idx_r, 1'b0});
    assign last_addr_s  = ADDR_WIDTH'({idx_r, 1'b1});
    assign nei_addr_s   = ADDR_WIDTH'({mem.g_rdata, ~l_step_r[0]});

    // One restoring-division iteration per cycle.
    always_comb begin
        rem_sh_s = {rem_r, quo_r[DATA_WIDTH-1]};
        if (rem_sh_s >= {1'b0, div_r}) begin
            rem_nx_s = DATA_WIDTH'(rem_sh_s - {1'b0, div_r});
            quo_nx_s = {quo_r[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_nx_s = rem_sh_s[DATA_WIDTH-1:0];
            quo_nx_s = {quo_r[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // Step sequencer and all registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            l_step_r      <= '0;
            node_offset_r <= '0;
            node_num_r    <= '0;
            idx_r         <= '0;
            prev_r        <= '0;
            first_r       <= '0;
            last_r        <= '0;
            ptr_r         <= '0;
            quo_r         <= '0;
            rem_r         <= '0;
            div_r         <= '0;
            cnt_r         <= '0;
            ph_r          <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            g_addr_r      <= '0;
            g_rd_en_r     <= 1'b0;
            s_req_r       <= 1'b0;
            s_addr_r      <= '0;
            s_wdata_r     <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        l_step_r      <= l_step;
                        node_offset_r <= node_offset;
                        node_num_r    <= node_num;
                        idx_r         <= '0;
                        busy_r        <= 1'b1;
                        state_r       <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (l_step_r >= DATA_WIDTH'(MAX_STEPS) || node_num_r == '0) begin
                        done_r  <= 1'b1;
                        state_r <= ST_FIN;
                    end else begin
                        s_addr_r <= prev_cur_s;
                        s_req_r  <= 1'b1;
                        ph_r     <= 1'b0;
                        state_r  <= ST_RD_PREV;
                    end
                end
                ST_RD_PREV: begin
                    if (!ph_r) begin
                        if (s_ok_s) begin
                            ph_r  <= 1'b1;
                            cnt_r <= '0;
                        end
                    end else if (lat_done_s) begin
                        prev_r    <= mem.s_rdata;
                        s_req_r   <= 1'b0;
                        g_addr_r  <= first_addr_s;
                        g_rd_en_r <= 1'b1;
                        ph_r      <= 1'b0;
                        state_r   <= ST_RD_FIRST;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_RD_FIRST: begin
                    if (!ph_r) begin
                        g_rd_en_r <= 1'b0;
                        ph_r      <= 1'b1;
                        cnt_r     <= '0;
                    end else if (lat_done_s) begin
                        first_r   <= mem.g_rdata;
                        g_addr_r  <= last_addr_s;
                        g_rd_en_r <= 1'b1;
                        ph_r      <= 1'b0;
                        state_r   <= ST_RD_LAST;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_RD_LAST: begin
                    if (!ph_r) begin
                        g_rd_en_r <= 1'b0;
                        ph_r      <= 1'b1;
                        cnt_r     <= '0;
                    end else if (lat_done_s) begin
                        last_r <= mem.g_rdata;
                        ph_r   <= 1'b0;
                        // last < first marks a node without neighbours.
                        if (mem.g_rdata < first_r) begin
                            state_r <= ST_NEXT;
                        end else begin
                            div_r   <= mem.g_rdata - first_r + DATA_WIDTH'(1);
                            rem_r   <= '0;
                            quo_r   <= prev_r;
                            cnt_r   <= '0;
                            state_r <= ST_DIV;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DIV: begin
                    rem_r <= rem_nx_s;
                    quo_r <= quo_nx_s;
                    if (cnt_r == CW'(DATA_WIDTH - 1)) begin
                        ptr_r     <= first_r;
                        g_addr_r  <= ADDR_WIDTH'(first_r);
                        g_rd_en_r <= 1'b1;
                        ph_r      <= 1'b0;
                        state_r   <= ST_RD_NEI;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_RD_NEI: begin
                    if (!ph_r) begin
                        g_rd_en_r <= 1'b0;
                        ph_r      <= 1'b1;
                        cnt_r     <= '0;
                    end else if (lat_done_s) begin
                        s_addr_r <= nei_addr_s;
                        s_req_r  <= 1'b1;
                        ph_r     <= 1'b0;
                        state_r  <= ST_RD_NS;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_RD_NS: begin
                    if (!ph_r) begin
                        if (s_ok_s) begin
                            ph_r  <= 1'b1;
                            cnt_r <= '0;
                        end
                    end else if (lat_done_s) begin
                        s_wdata_r <= sat_add(mem.s_rdata, quo_r);
                        s_req_r   <= 1'b0;
                        ph_r      <= 1'b0;
                        state_r   <= ST_WR_NS;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_WR_NS: begin
                    // First cycle keeps s_req low so the scheduler sees a gap after the read.
                    if (!s_req_r) begin
                        s_req_r <= 1'b1;
                    end else if (mem.s_gnt) begin
                        s_req_r <= 1'b0;
                        if (ptr_r == last_r) begin
                            state_r <= ST_NEXT;
                        end else begin
                            ptr_r     <= ptr_r + DATA_WIDTH'(1);
                            g_addr_r  <= ADDR_WIDTH'(ptr_r + DATA_WIDTH'(1));
                            g_rd_en_r <= 1'b1;
                            ph_r      <= 1'b0;
                            state_r   <= ST_RD_NEI;
                        end
                    end
                end
                ST_NEXT: begin
                    if (idx_nx_s == node_num_r) begin
                        done_r  <= 1'b1;
                        state_r <= ST_FIN;
                    end else begin
                        idx_r    <= idx_nx_s;
                        s_addr_r <= prev_nx_s;
                        s_req_r  <= 1'b1;
                        ph_r     <= 1'b0;
                        state_r  <= ST_RD_PREV;
                    end
                end
                ST_FIN: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r    <= 1'b0;
                    s_req_r   <= 1'b0;
                    g_rd_en_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign mem.g_addr  = g_addr_r;
    assign mem.g_rd_en = g_rd_en_r;
    assign mem.s_req   = s_req_r;
    assign mem.s_addr  = s_addr_r;
    assign mem.s_wdata = s_wdata_r;
    // Strobes need the grant of the current cycle, so they are qualified here.
    assign mem.s_rd_en = s_ok_s && (state_r == ST_RD_PREV || state_r == ST_RD_NS);
    assign mem.s_we    = s_ok_s && (state_r == ST_WR_NS);
endmodule

// File: doc/diffusion_push_engine.md
Name: diffusion_push_engine

Overview:
- Parametrised, fully synchronous successor of the single-partition diffusion random-walk updater.
- For each node of one partition, reads the node's previous score, divides it by the node's degree, and adds the quotient to the latest score of every neighbour.
- Graph data comes from the subgraph BRAM; scores live in the ping-pong score table, which is shared through the scheduler via a req/gnt handshake.
- A start/done handshake runs one diffusion step per start pulse. Node offset and count are runtime ports.

Parameters:
- DATA_WIDTH, 32, score width and graph word width.
- ADDR_WIDTH, 13, address width of both BRAM ports.
- RD_LAT, 1, BRAM read latency in cycles (1..3), identical for both memories.
- MAX_STEPS, 7, steps with l_step >= MAX_STEPS perform no work.
- SATURATE, 1, 1 = score add saturates at all-ones; 0 = add wraps modulo 2^DATA_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- l_step  in  DATA_WIDTH  step index, latched at start; bit0 selects the ping-pong slot.
- node_offset  in  ADDR_WIDTH  global id of the partition's first node, latched at start.
- node_num  in  ADDR_WIDTH  nodes in the partition, latched at start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the step completes.
- g_addr  out  ADDR_WIDTH  graph read address.
- g_rd_en  out  1  graph read strobe.
- g_rdata  in  DATA_WIDTH  graph read data, valid RD_LAT cycles after the strobe.
- s_req  out  1  score-port request to the scheduler.
- s_gnt  in  1  scheduler grant.
- s_addr  out  ADDR_WIDTH  score address.
- s_rd_en  out  1  score read strobe.
- s_we  out  1  score write enable.
- s_wdata  out  DATA_WIDTH  score write data.
- s_rdata  in  DATA_WIDTH  score read data, valid RD_LAT cycles after the strobe.

Behaviour:
- Reset: all outputs are 0, state is IDLE, all latched registers are 0. Reset mid-operation aborts immediately with no further write; the partially updated table is the caller's responsibility.
- Memory layout:
  - Graph: word 2*i = first neighbour pointer of local node i (0-based); word 2*i+1 = last neighbour pointer (inclusive). Pointed words hold global neighbour ids.
  - Score table: global node n occupies words 2n and 2n+1.
  - prev slot = 2n + l_step[0]; latest slot = 2n + !l_step[0].
- States:
  - IDLE.
  - CHK: if l_step >= MAX_STEPS or node_num == 0, go to FIN.
  - RD_PREV: score read of prev slot of (node_offset+i).
  - RD_FIRST, RD_LAST: graph reads.
  - DIV.
  - RD_NEI: graph read at the pointer.
  - RD_NS: score read of the neighbour's latest slot.
  - WR_NS.
  - NEXT.
  - FIN: pulse done, return to IDLE.
- Score handshake:
  - s_req is high in RD_PREV, RD_NS and WR_NS.
  - A strobe (s_rd_en/s_we) is issued only in a cycle where s_req && s_gnt; otherwise address, data and state hold.
  - s_req stays high through the read latency wait; it drops for one cycle between accesses.
- Read waits: after each strobe, count RD_LAT cycles, then capture the data.
- Degree = last - first + 1. If last < first, the node is a zero-degree node: skip directly to NEXT with no score writes.
- DIV: restoring sequential divider computing prev / degree, unsigned. Takes exactly DATA_WIDTH cycles. The quotient is held for all neighbours of the node.
- WR_NS:
  - Writes latest + quotient, saturated if SATURATE=1.
  - One write cycle, after which the pointer increments.
  - Each neighbour's read-modify-write completes before the next read begins, so duplicate neighbour ids accumulate correctly.
- NEXT: i++. If i == node_num, go to FIN; otherwise go to RD_PREV.
- Stall: start asserted while busy is ignored.

Test Plan:
- Early exit: l_step=7, start -> done one cycle after CHK; no g_rd_en, s_req or s_we ever asserted.
- One-node step:
  - Setup: node_offset=0, node_num=1, l_step=0, graph {0:2, 1:4, 2:1, 3:2, 4:3}; scores prev[0]=90, latest[1..3]=5.
  - Expected: latest words 3, 5, 7 become 35; done pulses once.
- Ping-pong: same graph with l_step=1 -> reads word 1 as prev; writes land in the even slots 2, 4, 6.
- Grant stall: hold s_gnt=0 for 20 cycles during RD_NS -> s_addr stable and no strobe during the stall; final results identical to the no-stall run.
- Edge cases: zero-degree node (first=5, last=4) is skipped with no writes. Duplicate neighbour listed twice, prev=10, degree=2 -> its latest score increases by 10. With SATURATE=1, latest=0xFFFFFFF0 plus quotient 0x20 -> 0xFFFFFFFF.
- Reset abort: deassert rst_n during DIV -> all outputs 0 immediately; the next start runs a full, correct step.
